// File: rtl/isa_pkg.sv
// ISA constants shared by the decode stage and its register file.
// Opcodes, ALU commands, branch kinds, field positions and the opcode decoder.
package isa_pkg;

    localparam int REG_AW = 5;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int SRC1_HI = 25;
    localparam int SRC1_LO = 21;
    localparam int SRC2_HI = 20;
    localparam int SRC2_LO = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int IMM_HI  = 15;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;
    localparam logic [5:0] OP_OR   = 6'b000110;
    localparam logic [5:0] OP_NOR  = 6'b000111;
    localparam logic [5:0] OP_XOR  = 6'b001000;
    localparam logic [5:0] OP_SLA  = 6'b001001;
    localparam logic [5:0] OP_SLL  = 6'b001010;
    localparam logic [5:0] OP_SRA  = 6'b001011;
    localparam logic [5:0] OP_SRL  = 6'b001100;
    localparam logic [5:0] OP_ADDI = 6'b100000;
    localparam logic [5:0] OP_SUBI = 6'b100001;
    localparam logic [5:0] OP_LD   = 6'b100100;
    localparam logic [5:0] OP_ST   = 6'b100101;
    localparam logic [5:0] OP_BEZ  = 6'b101000;
    localparam logic [5:0] OP_BNE  = 6'b101001;
    localparam logic [5:0] OP_JMP  = 6'b101010;

    typedef enum logic [3:0] {
        CMD_ADD = 4'b0000,
        CMD_SUB = 4'b0010,
        CMD_AND = 4'b0100,
        CMD_OR  = 4'b0101,
        CMD_NOR = 4'b0110,
        CMD_XOR = 4'b0111,
        CMD_SHL = 4'b1000,
        CMD_SRA = 4'b1001,
        CMD_SRL = 4'b1010
    } exe_cmd_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

    typedef struct packed {
        logic     bubble;
        logic     rtype;
        logic     use1;
        logic     use2;
        exe_cmd_e cmd;
        logic     mem_r;
        logic     mem_w;
        logic     wb;
        br_type_e br;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d        = '0;
        d.cmd    = CMD_ADD;
        d.br     = BR_NONE;
        d.use1   = 1'b1;
        d.wb     = 1'b1;
        d.rtype  = 1'b1;
        d.use2   = 1'b1;
        case (op)
            OP_ADD:          d.cmd = CMD_ADD;
            OP_SUB:          d.cmd = CMD_SUB;
            OP_AND:          d.cmd = CMD_AND;
            OP_OR:           d.cmd = CMD_OR;
            OP_NOR:          d.cmd = CMD_NOR;
            OP_XOR:          d.cmd = CMD_XOR;
            OP_SLA, OP_SLL:  d.cmd = CMD_SHL;
            OP_SRA:          d.cmd = CMD_SRA;
            OP_SRL:          d.cmd = CMD_SRL;
            default: begin
                d.rtype = 1'b0;
                d.use2  = 1'b0;
                case (op)
                    OP_ADDI: d.cmd = CMD_ADD;
                    OP_SUBI: d.cmd = CMD_SUB;
                    OP_LD:   d.mem_r = 1'b1;
                    OP_ST: begin
                        d.mem_w = 1'b1;
                        d.wb    = 1'b0;
                        d.use2  = 1'b1;
                    end
                    OP_BEZ: begin
                        d.br = BR_BEZ;
                        d.wb = 1'b0;
                    end
                    OP_BNE: begin
                        d.br   = BR_BNE;
                        d.wb   = 1'b0;
                        d.use2 = 1'b1;
                    end
                    OP_JMP: begin
                        d.br   = BR_JMP;
                        d.wb   = 1'b0;
                        d.use1 = 1'b0;
                    end
                    default: begin
                        d      = '0;
                        d.cmd  = CMD_ADD;
                        d.br   = BR_NONE;
                        d.bubble = 1'b1;
                    end
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two read ports, one write port, same-cycle bypass.
// r0 is hardwired to zero and never written.
module reg_file
    import isa_pkg::*;
#(
    parameter int REG_COUNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [31:0]       o_rdata1,
    output logic [31:0]       o_rdata2,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [31:0]       i_wdata
);

    logic [31:0] r_mem [REG_COUNT];
    logic        w_wr;

    assign w_wr = i_we && (i_waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++)
                r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Bypass lets a write-back and a dependent read share a cycle.
    always_comb begin
        o_rdata1 = '0;
        o_rdata2 = '0;
        if (i_raddr1 != '0)
            o_rdata1 = (w_wr && i_waddr == i_raddr1) ? i_wdata : r_mem[i_raddr1];
        if (i_raddr2 != '0)
            o_rdata2 = (w_wr && i_waddr == i_raddr2) ? i_wdata : r_mem[i_raddr2];
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode: decoder, operand read, RAW hazard freeze, ID/EX register.
// Flush, freeze and undefined opcodes all load a zero bubble into ID/EX.
module id_stage
    import isa_pkg::*;
#(
    parameter int REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_value,
    input  logic        exe_wb_en,
    input  logic [4:0]  exe_dest,
    input  logic        mem_wb_en,
    input  logic [4:0]  mem_dest,
    output logic        freeze,
    output logic [31:0] id_pc,
    output logic [31:0] id_val1,
    output logic [31:0] id_val2,
    output logic [31:0] id_st_val,
    output logic [4:0]  id_dest,
    output logic [3:0]  id_exe_cmd,
    output logic        id_mem_r_en,
    output logic        id_mem_w_en,
    output logic        id_wb_en,
    output logic [1:0]  id_br_type,
    output logic [31:0] id_br_off
);

    logic [5:0]  w_op;
    logic [4:0]  w_src1;
    logic [4:0]  w_src2;
    logic [4:0]  w_dest;
    logic [31:0] w_imm;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic        w_wb;
    logic        w_hit1;
    logic        w_hit2;
    dec_t        w_dec;

    assign w_op   = if_instr[OPC_HI:OPC_LO];
    assign w_src1 = if_instr[SRC1_HI:SRC1_LO];
    assign w_src2 = if_instr[SRC2_HI:SRC2_LO];
    assign w_imm  = {{16{if_instr[IMM_HI]}}, if_instr[IMM_HI:0]};
    assign w_dec  = decode(w_op);
    assign w_dest = w_dec.rtype ? if_instr[RD_HI:RD_LO] : w_src2;
    assign w_wb   = w_dec.wb && (w_dest != '0);

    reg_file #(
        .REG_COUNT(REG_COUNT)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_src1),
        .i_raddr2 (w_src2),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2),
        .i_we     (wb_en),
        .i_waddr  (wb_dest),
        .i_wdata  (wb_value)
    );

    always_comb begin
        w_hit1 = (w_src1 != '0) &&
                 ((exe_wb_en && exe_dest == w_src1) ||
                  (mem_wb_en && mem_dest == w_src1));
        w_hit2 = (w_src2 != '0) &&
                 ((exe_wb_en && exe_dest == w_src2) ||
                  (mem_wb_en && mem_dest == w_src2));
        freeze = (w_dec.use1 && w_hit1) || (w_dec.use2 && w_hit2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush || freeze || w_dec.bubble) begin
            id_pc       <= '0;
            id_val1     <= '0;
            id_val2     <= '0;
            id_st_val   <= '0;
            id_dest     <= '0;
            id_exe_cmd  <= '0;
            id_mem_r_en <= 1'b0;
            id_mem_w_en <= 1'b0;
            id_wb_en    <= 1'b0;
            id_br_type  <= '0;
            id_br_off   <= '0;
        end else begin
            id_pc       <= if_pc;
            id_val1     <= w_rd1;
            id_val2     <= w_dec.rtype ? w_rd2 : w_imm;
            id_st_val   <= w_rd2;
            id_dest     <= w_dest;
            id_exe_cmd  <= w_dec.cmd;
            id_mem_r_en <= w_dec.mem_r;
            id_mem_w_en <= w_dec.mem_w;
            id_wb_en    <= w_wb;
            id_br_type  <= w_dec.br;
            id_br_off   <= w_imm;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with hand-computed expectations.
// Inputs change #1 after a rising edge; outputs are sampled #1 after the next.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic        exe_wb_en;
    logic [4:0]  exe_dest;
    logic        mem_wb_en;
    logic [4:0]  mem_dest;
    logic        freeze;
    logic [31:0] id_pc;
    logic [31:0] id_val1;
    logic [31:0] id_val2;
    logic [31:0] id_st_val;
    logic [4:0]  id_dest;
    logic [3:0]  id_exe_cmd;
    logic        id_mem_r_en;
    logic        id_mem_w_en;
    logic        id_wb_en;
    logic [1:0]  id_br_type;
    logic [31:0] id_br_off;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_stage #(.REG_COUNT(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_value    (wb_value),
        .exe_wb_en   (exe_wb_en),
        .exe_dest    (exe_dest),
        .mem_wb_en   (mem_wb_en),
        .mem_dest    (mem_dest),
        .freeze      (freeze),
        .id_pc       (id_pc),
        .id_val1     (id_val1),
        .id_val2     (id_val2),
        .id_st_val   (id_st_val),
        .id_dest     (id_dest),
        .id_exe_cmd  (id_exe_cmd),
        .id_mem_r_en (id_mem_r_en),
        .id_mem_w_en (id_mem_w_en),
        .id_wb_en    (id_wb_en),
        .id_br_type  (id_br_type),
        .id_br_off   (id_br_off)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".all"}, {id_pc | id_val1 | id_val2 | id_st_val | id_br_off},
            32'h0);
        chk({tag, ".ctl"}, {19'd0, id_dest, id_exe_cmd, id_mem_r_en,
            id_mem_w_en, id_wb_en, id_br_type}, 32'h0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; if_pc = '0; if_instr = '0;
        wb_en = 1'b0; wb_dest = '0; wb_value = '0;
        exe_wb_en = 1'b0; exe_dest = '0; mem_wb_en = 1'b0; mem_dest = '0;
        #12;
        chk_zero("reset");
        chk("reset.freeze", {31'd0, freeze}, 32'h0);
        rst = 1'b0;
        step();

        // ADDI r1,r0,1546
        if_pc = 32'h4; if_instr = 32'h8001060A;
        step();
        chk("addi.pc", id_pc, 32'h4);
        chk("addi.val1", id_val1, 32'h0);
        chk("addi.val2", id_val2, 32'd1546);
        chk("addi.dest", {27'd0, id_dest}, 32'd1);
        chk("addi.cmd", {28'd0, id_exe_cmd}, 32'h0);
        chk("addi.wb", {31'd0, id_wb_en}, 32'h1);

        // write r1 and read it in the same cycle
        wb_en = 1'b1; wb_dest = 5'd1; wb_value = 32'h60A;
        if_pc = 32'h8; if_instr = 32'h04011000;
        #1;
        chk("add.freeze", {31'd0, freeze}, 32'h0);
        step();
        chk("add.val2", id_val2, 32'h60A);
        chk("add.val1", id_val1, 32'h0);
        chk("add.dest", {27'd0, id_dest}, 32'd2);

        // write r2 behind a nop
        wb_dest = 5'd2; wb_value = 32'h1234; if_instr = 32'h0;
        step();
        chk_zero("nop");
        wb_en = 1'b0;

        // SUB r3,r0,r1 against EXE writer of r1
        if_pc = 32'hC; if_instr = 32'h0C011800;
        exe_wb_en = 1'b1; exe_dest = 5'd1;
        #1;
        chk("sub.freeze", {31'd0, freeze}, 32'h1);
        step();
        chk_zero("sub.bubble");
        exe_wb_en = 1'b0;
        #1;
        chk("sub.unfreeze", {31'd0, freeze}, 32'h0);
        step();
        chk("sub.cmd", {28'd0, id_exe_cmd}, 32'h2);
        chk("sub.dest", {27'd0, id_dest}, 32'd3);
        chk("sub.val2", id_val2, 32'h60A);
        chk("sub.wb", {31'd0, id_wb_en}, 32'h1);

        // ST r2,r1,0 against MEM writer of r2
        if_pc = 32'h10; if_instr = 32'h94220000;
        mem_wb_en = 1'b1; mem_dest = 5'd2;
        #1;
        chk("st.freeze", {31'd0, freeze}, 32'h1);
        step();
        chk("st.bubble", {31'd0, id_mem_w_en}, 32'h0);
        mem_wb_en = 1'b0;
        step();
        chk("st.memw", {31'd0, id_mem_w_en}, 32'h1);
        chk("st.stval", id_st_val, 32'h1234);
        chk("st.wb", {31'd0, id_wb_en}, 32'h0);
        chk("st.val1", id_val1, 32'h60A);
        chk("st.val2", id_val2, 32'h0);

        // BNE r1,r3,-15 flushed, also while frozen
        if_pc = 32'h14; if_instr = 32'hA423FFF1;
        flush = 1'b1; exe_wb_en = 1'b1; exe_dest = 5'd3;
        #1;
        chk("bne.freeze", {31'd0, freeze}, 32'h1);
        step();
        chk_zero("bne.flush");
        exe_wb_en = 1'b0;
        step();
        chk_zero("bne.flush2");
        flush = 1'b0;
        step();
        chk("bne.br", {30'd0, id_br_type}, 32'd2);
        chk("bne.off", id_br_off, 32'hFFFFFFF1);
        chk("bne.wb", {31'd0, id_wb_en}, 32'h0);

        // JMP ignores src1 for hazards
        if_instr = 32'hA8200000; exe_wb_en = 1'b1; exe_dest = 5'd1;
        #1;
        chk("jmp.freeze", {31'd0, freeze}, 32'h0);
        step();
        chk("jmp.br", {30'd0, id_br_type}, 32'd3);
        exe_wb_en = 1'b0;

        // SRA r5,r1,r2
        if_instr = 32'h2C222800;
        step();
        chk("sra.cmd", {28'd0, id_exe_cmd}, 32'h9);
        chk("sra.val1", id_val1, 32'h60A);
        chk("sra.val2", id_val2, 32'h1234);

        // ADDI r0,r1,5: write-back to r0 suppressed
        if_instr = 32'h80200005;
        step();
        chk("addi0.wb", {31'd0, id_wb_en}, 32'h0);
        chk("addi0.val2", id_val2, 32'h5);

        // undefined opcode
        if_instr = 32'hFC000000;
        step();
        chk_zero("undef");

        // write r0 alongside ADD r4,r0,r0
        wb_en = 1'b1; wb_dest = 5'd0; wb_value = 32'hDEADBEEF;
        if_instr = 32'h04002000;
        step();
        chk("r0.val1", id_val1, 32'h0);
        chk("r0.val2", id_val2, 32'h0);
        chk("r0.dest", {27'd0, id_dest}, 32'd4);
        wb_en = 1'b0;
        step();
        chk("r0.after", id_val1 | id_val2, 32'h0);

        // async reset mid-run clears outputs and registers
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst.async");
        step();
        rst = 1'b0;
        if_instr = 32'h04213000;
        step();
        chk("rst.rf", id_val1 | id_val2, 32'h0);
        chk("rst.dest", {27'd0, id_dest}, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
